// File: rtl/rr_arb_ctrl.sv
// ---------------------------------------------------------------------------
// rr_arb_ctrl -- round-robin arbiter with per-ownership hold limit.
//
// Requesters raise req[i] and keep it high for as long as they need the
// shared resource. The arbiter answers with a registered one-hot gnt. The
// owner releases by dropping req. An owner that keeps req high for MAX_HOLD
// grant cycles has the grant revoked (timeout pulse). It is then locked out
// (expired[i]) until it drops req at least once.
//
// Handshake: req[i] acts as "valid" and gnt[i] as "ready/accept". A request
// is accepted at the first rising edge where the arbiter is IDLE, en=1 and
// i wins the round-robin search. The transfer window lasts while both req[i]
// and gnt[i] are high. It ends at the edge that samples req[i]=0, or at
// MAX_HOLD expiry. A request must not be withdrawn and re-raised in order to
// observe gnt; gnt is only ever asserted the cycle after acceptance.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   en           arbitration enable (blocks new grants only)
//   req[N]       per-requester request
//   gnt[N]       registered one-hot grant, zero when idle
//   gnt_valid    OR of gnt (registered)
//   gnt_id       index of current owner, holds last owner when idle
//   timeout      one-cycle pulse when a grant is revoked by expiry
//   expired[N]   per-requester lockout flags
//   dbg_state    FSM state (0 = IDLE, 1 = GRANT)
//   dbg_hold_cnt current hold counter
// ---------------------------------------------------------------------------
module rr_arb_ctrl #(
    parameter int  N        = 4,
    parameter int  MAX_HOLD = 16,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout,
    output logic [N-1:0]   expired,
    output logic           dbg_state,
    output logic [7:0]     dbg_hold_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         state_q,     state_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [7:0]     hold_cnt_q,  hold_cnt_d;
    logic [N-1:0]   gnt_q,       gnt_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0] gnt_id_q,    gnt_id_d;
    logic           timeout_q,   timeout_d;
    logic [N-1:0]   expired_q,   expired_d;

    logic [N-1:0]   eligible;
    logic           win_found;
    logic [IDW-1:0] win_id;

    // (base + off) mod N, with off < N; the extra bit keeps the sum exact.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + (IDW+1)'(off);
        if (sum >= (IDW+1)'(N)) begin
            sum = sum - (IDW+1)'(N);
        end
        return sum[IDW-1:0];
    endfunction

    // Round-robin search: first eligible index at or above ptr, wrapping.
    always_comb begin
        eligible  = req & ~expired_q;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && eligible[wrap_add(ptr_q, k)]) begin
                win_found = 1'b1;
                win_id    = wrap_add(ptr_q, k);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        timeout_d  = 1'b0;
        // A lockout flag clears at the first edge that sees its req low.
        expired_d  = expired_q & req;

        case (state_q)
            ST_IDLE: begin
                gnt_d      = '0;
                hold_cnt_d = '0;
                if (en && win_found) begin
                    state_d         = ST_GRANT;
                    gnt_d[win_id]   = 1'b1;
                    gnt_id_d        = win_id;
                    ptr_d           = wrap_add(win_id, 1);
                    hold_cnt_d      = 8'd1;
                end
            end
            ST_GRANT: begin
                // Release is checked first so it wins over a same-edge expiry.
                if (!req[gnt_id_q]) begin
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == 8'(MAX_HOLD)) begin
                    state_d             = ST_IDLE;
                    gnt_d               = '0;
                    hold_cnt_d          = '0;
                    timeout_d           = 1'b1;
                    expired_d[gnt_id_q] = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                hold_cnt_d = '0;
            end
        endcase

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= 1'b0;
            expired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            timeout_q   <= timeout_d;
            expired_q   <= expired_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_valid    = gnt_valid_q;
    assign gnt_id       = gnt_id_q;
    assign timeout      = timeout_q;
    assign expired      = expired_q;
    assign dbg_state    = state_q;
    assign dbg_hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_ctrl -- self-checking bench for rr_arb_ctrl (N=4, MAX_HOLD=16).
// A behavioural reference model tracks owner, hold length, pointer and
// lockouts from the arbitration rules; scenario tasks add directed checks.
// ---------------------------------------------------------------------------
module tb_rr_arb_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;
    localparam int IDW      = $clog2(N);
    localparam int VW       = 2 * N + IDW + 2;

    // ---------------- clock / reset ----------------
    logic           clock   = 1'b0;
    logic           reset_n = 1'b0;
    logic           en      = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           timeout;
    logic [N-1:0]   expired;
    logic           dbg_state;
    logic [7:0]     dbg_hold_cnt;

    always #5 clock = ~clock;

    rr_arb_ctrl #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .en           (en),
        .req          (req),
        .gnt          (gnt),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .timeout      (timeout),
        .expired      (expired),
        .dbg_state    (dbg_state),
        .dbg_hold_cnt (dbg_hold_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [VW-1:0] act;
    assign act = {gnt, gnt_valid, gnt_id, timeout, expired};

    // ---------------- reference model ----------------
    int           m_busy  = 0;
    int           m_owner = 0;
    int           m_hold  = 0;
    int           m_ptr   = 0;
    logic         m_to    = 1'b0;
    logic [N-1:0] m_exp   = '0;

    always @(posedge clock or negedge reset_n) begin : ref_model
        logic [N-1:0] nx_exp;
        int           w;
        if (!reset_n) begin
            m_busy  = 0;
            m_owner = 0;
            m_hold  = 0;
            m_ptr   = 0;
            m_to    = 1'b0;
            m_exp   = '0;
        end else begin
            m_to   = 1'b0;
            nx_exp = m_exp & req;
            if (m_busy != 0) begin
                if (req[m_owner] == 1'b0) begin
                    m_busy = 0;
                end else if (m_hold == MAX_HOLD) begin
                    m_busy         = 0;
                    m_to           = 1'b1;
                    nx_exp[m_owner] = 1'b1;
                end else begin
                    m_hold = m_hold + 1;
                end
            end else if (en) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && req[(m_ptr + k) % N] && !m_exp[(m_ptr + k) % N]) begin
                        w = (m_ptr + k) % N;
                    end
                end
                if (w >= 0) begin
                    m_busy  = 1;
                    m_owner = w;
                    m_hold  = 1;
                    m_ptr   = (w + 1) % N;
                end
            end
            m_exp = nx_exp;
        end
    end

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_busy != 0) g[m_owner] = 1'b1;
        return {g, |g, IDW'(m_owner), m_to, m_exp};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        en      = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req     = '1;
        en      = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL reset_outputs act=%h exp=%h", act, {VW{1'b0}});
        end
        total++;
        if (dbg_state !== 1'b0 || dbg_hold_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_state act=%b/%0d exp=0/0", dbg_state, dbg_hold_cnt);
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (act !== model_vec()) begin
            bad++;
            $display("FAIL reset_model act=%h exp=%h", act, model_vec());
        end
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_ptr act=%b exp=0001", gnt);
        end
        req = '0;
        en  = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_single();
        logic [N-1:0] want;
        do_reset();
        en  = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            want = (i < 3) ? 4'b0001 : 4'b0000;
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL single_model cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
            total++;
            if (gnt !== want) begin
                bad++;
                $display("FAIL single_gnt cyc=%0d act=%b exp=%b", i, gnt, want);
            end
            if (i == 2) req = '0;
        end
        total++;
        if (gnt_id !== 2'd0) begin
            bad++;
            $display("FAIL single_id act=%0d exp=0", gnt_id);
        end
    endtask

    task automatic test_round_robin();
        int           order[$];
        int           exp_order[5] = '{0, 1, 2, 3, 0};
        int           run = 0;
        logic         prev_valid = 1'b0;
        logic [N-1:0] prev_gnt = '0;
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 40 && order.size() < 5; i++) begin
            tick();
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL rr_model cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
            total++;
            if (prev_gnt !== '0 && gnt !== '0 && gnt !== prev_gnt) begin
                bad++;
                $display("FAIL rr_gap act=%b prev=%b exp=idle_between", gnt, prev_gnt);
            end
            if (gnt_valid && !prev_valid) begin
                order.push_back(int'(gnt_id));
                run = 0;
            end
            prev_valid = gnt_valid;
            prev_gnt   = gnt;
            if (gnt_valid) begin
                run++;
                if (run == 2) req[gnt_id] = 1'b0;
            end else begin
                req = 4'b1111;
            end
        end
        total++;
        if (order.size() != 5) begin
            bad++;
            $display("FAIL rr_count act=%0d exp=5", order.size());
        end
        for (int k = 0; k < 5 && k < order.size(); k++) begin
            total++;
            if (order[k] != exp_order[k]) begin
                bad++;
                $display("FAIL rr_order idx=%0d act=%0d exp=%0d", k, order[k], exp_order[k]);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int gcyc = 0;
        int tcnt = 0;
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL to_model cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
            if (gnt === 4'b0010) gcyc++;
            if (timeout === 1'b1) tcnt++;
        end
        total++;
        if (gcyc != MAX_HOLD) begin
            bad++;
            $display("FAIL to_hold_len act=%0d exp=%0d", gcyc, MAX_HOLD);
        end
        total++;
        if (tcnt != 1) begin
            bad++;
            $display("FAIL to_pulse act=%0d exp=1", tcnt);
        end
        total++;
        if (expired !== 4'b0010 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL to_lock act=%b/%b exp=0010/0000", expired, gnt);
        end
        req = '0;
        tick();
        total++;
        if (expired !== 4'b0000) begin
            bad++;
            $display("FAIL to_clear act=%b exp=0000", expired);
        end
        req = 4'b0010;
        tick();
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL to_regrant act=%b exp=0010", gnt);
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_lockout();
        int   first1 = -1;
        logic exp0_at_grant = 1'b0;
        do_reset();
        en  = 1'b1;
        req = 4'b0011;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL lock_model cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
            if (first1 < 0 && gnt === 4'b0010) begin
                first1        = i;
                exp0_at_grant = expired[0];
            end
        end
        total++;
        if (first1 != MAX_HOLD + 1 || exp0_at_grant !== 1'b1) begin
            bad++;
            $display("FAIL lock_next act=cyc%0d/exp%b exp=cyc%0d/exp1", first1, exp0_at_grant, MAX_HOLD + 1);
        end
        // Requester 1 releases; requester 0 is still locked out.
        req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0000 || act !== model_vec()) begin
                bad++;
                $display("FAIL lock_hold cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_en_gating();
        do_reset();
        en  = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0000 || act !== model_vec()) begin
                bad++;
                $display("FAIL en_block cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
        end
        en = 1'b1;
        tick();
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL en_grant act=%b exp=0100", gnt);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0100 || act !== model_vec()) begin
                bad++;
                $display("FAIL en_persist cyc=%0d act=%b exp=0100", i, gnt);
            end
        end
        req = '0;
        tick();
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL en_release act=%b exp=0000", gnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        // Lock requester 1 out so a non-zero expired is present at reset.
        for (int i = 0; i < MAX_HOLD + 2; i++) begin
            tick();
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL rst_pre cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
        end
        req = 4'b0110;
        repeat (5) tick();
        total++;
        if (gnt !== 4'b0100 || expired !== 4'b0010) begin
            bad++;
            $display("FAIL rst_setup act=%b/%b exp=0100/0010", gnt, expired);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (act !== '0) begin
            bad++;
            $display("FAIL rst_async act=%h exp=%h", act, {VW{1'b0}});
        end
        tick();
        total++;
        if (act !== '0 || act !== model_vec()) begin
            bad++;
            $display("FAIL rst_held act=%h exp=%h", act, model_vec());
        end
        reset_n = 1'b1;
        req     = 4'b1001;
        tick();
        total++;
        if (gnt !== 4'b0001 || act !== model_vec()) begin
            bad++;
            $display("FAIL rst_ptr act=%h exp=%h", act, model_vec());
        end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int seen_to = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 23) == 0) req[b] = ~req[b];
            end
            en = ($urandom_range(0, 9) != 0);
            tick();
            total++;
            if (act !== model_vec()) begin
                bad++;
                $display("FAIL rand_model cyc=%0d act=%h exp=%h", i, act, model_vec());
            end
            total++;
            if ($countones(gnt) > 1 || dbg_hold_cnt > 8'(MAX_HOLD)) begin
                bad++;
                $display("FAIL rand_invariant cyc=%0d act=%b/%0d exp=onehot/<=%0d", i, gnt, dbg_hold_cnt, MAX_HOLD);
            end
            if (timeout === 1'b1) seen_to++;
        end
        total++;
        if (seen_to == 0) begin
            bad++;
            $display("FAIL rand_timeouts act=%0d exp=>0", seen_to);
        end
        req = '0;
        en  = 1'b0;
        tick();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_lockout();
        test_en_gating();
        test_reset_mid_grant();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_ctrl.md
RR_ARB_CTRL -- requirements
Module: rr_arb_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter MAX_HOLD, default 16, meaning maximum consecutive grant cycles per ownership (2..255).
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  arbitration enable; low blocks new grants only.
REQ-006 SHALL have port req  input  N  per-requester request, held high for the whole of use.
REQ-007 SHALL have port gnt  output  N  registered one-hot grant; all-zero when idle.
REQ-008 SHALL have port gnt_valid  output  1  high when any gnt bit is high.
REQ-009 SHALL have port gnt_id  output  clog2(N)  index of current owner; holds last owner when idle.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.
REQ-011 SHALL have port expired  output  N  per-requester lockout flags.

Function
REQ-012 SHALL implement FSM states IDLE and GRANT only.
REQ-013 IDLE: at a rising edge with en=1 and any eligible request (req[i]=1 and expired[i]=0), SHALL go to GRANT and assert gnt of the winner, visible the cycle after req is sampled (latency 1).
REQ-014 Winner SHALL be the first eligible index found searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-015 On each grant, ptr SHALL be set to (winner+1) mod N; ptr SHALL not change otherwise.
REQ-016 IDLE with en=0 or no eligible request: SHALL stay in IDLE, gnt=0.
REQ-017 GRANT: hold_cnt SHALL be 1 in the first grant cycle and increment by 1 each further cycle while held.
REQ-018 GRANT, edge sampling req[owner]=0: SHALL return to IDLE, gnt=0 next cycle, no timeout.
REQ-019 GRANT, edge with req[owner]=1 and hold_cnt=MAX_HOLD: SHALL return to IDLE, gnt=0, pulse timeout for exactly one cycle, set expired[owner].
REQ-020 Release and expiry sampled on the same edge: release SHALL take priority (no timeout, expired unchanged).
REQ-021 expired[i] SHALL clear at the first edge sampling req[i]=0; an expired requester SHALL be ineligible while the flag is set.
REQ-022 At least one IDLE cycle (gnt all-zero) SHALL separate any two grants, including back-to-back grants to different requesters.
REQ-023 en deasserted during GRANT SHALL NOT revoke the current grant; release and expiry rules still apply.
REQ-024 Changes of non-owner req bits during GRANT SHALL have no effect on gnt.
REQ-025 gnt SHALL never have more than one bit set; gnt_valid SHALL equal OR of gnt.
REQ-026 hold_cnt SHALL be 8 bits wide and SHALL never exceed MAX_HOLD.

Reset
REQ-027 reset_n low SHALL immediately, without a clock edge, force: state IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, expired=0, ptr=0, hold_cnt=0.
REQ-028 Reset asserted mid-grant SHALL drop gnt at once; after reset_n rises, the first arbitration SHALL start from ptr=0.
REQ-029 Outputs SHALL be glitch-free registered values after reset release; no grant on the first edge sampling reset_n low.

Verification
REQ-030 Single request: req=0001 held 3 cycles then 0 -> gnt=0001 from the cycle after first sample, for 3 cycles; gnt_id=0; then gnt=0.
REQ-031 Round-robin: req=1111 held; each owner drops req after 2 grant cycles then reasserts -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-032 Timeout: MAX_HOLD=16, req=0010 held 40 cycles -> gnt=0010 for exactly 16 cycles, timeout pulse 1 cycle, expired=0010, no regrant until req[1] falls and rises again.
REQ-033 Lockout fairness: req=0011 held, requester 0 times out -> next grant goes to 1 while expired[0]=1.
REQ-034 en gating: en=0, req=0100 -> gnt stays 0; en=1 -> gnt=0100 one cycle later; en=0 during grant -> grant persists.
REQ-035 Reset mid-grant: reset_n low in grant cycle 5 -> gnt, gnt_valid, timeout, expired all 0 immediately; after release, req=1001 -> gnt=0001.
